// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// The slave modport belongs to the unit. The master modport belongs to the
// environment around it: the pipeline memory stage plus the data memory.
interface mem_access_unit_if #(
    parameter int address_width = 32,
    parameter int word_size     = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [2:0]               req_funct3;
    logic [address_width-1:0] req_addr;
    logic [word_size-1:0]     req_wdata;
    logic                     rsp_valid;
    logic [word_size-1:0]     rsp_rdata;
    logic                     rsp_error;
    logic                     mem_we;
    logic [address_width-1:0] mem_addr;
    logic [word_size-1:0]     mem_wr_data;
    logic [word_size-1:0]     mem_rd_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               mem_we, mem_addr, mem_wr_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               mem_we, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for a word-organised data memory with combinational
// read and synchronous write. Sub-word stores are done as read-modify-write:
// the old word is read in the accept cycle, and the merged word is written
// in the following WRITE cycle.
module mem_access_unit #(
    parameter int address_width = 32,
    parameter int word_size     = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Decide whether a request is illegal or misaligned.
    // Illegal means a funct3 code that is not valid for the direction.
    // Misaligned means a halfword on an odd address, or a word that is not
    // on a 4-byte boundary.
    function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (we) begin
            case (f3)
                3'b000, 3'b001, 3'b010: bad = 1'b0;
                default:                bad = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
                default:                                bad = 1'b1;
            endcase
        end
        if (!bad) begin
            case (f3[1:0])
                2'b01:   bad = off[0];
                2'b10:   bad = (off != 2'b00);
                default: bad = 1'b0;
            endcase
        end else begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Little-endian byte/halfword extraction, sign- or zero-extended.
    function automatic logic [word_size-1:0] load_extract(
        input logic [word_size-1:0] word, input logic [2:0] f3,
        input logic [1:0] off);
        logic [7:0]           b;
        logic [15:0]          h;
        logic [word_size-1:0] res;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{(word_size-8){b[7]}}, b};
            3'b001:  res = {{(word_size-16){h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {{(word_size-8){1'b0}}, b};
            3'b101:  res = {{(word_size-16){1'b0}}, h};
            default: res = {word_size{1'b0}};
        endcase
        return res;
    endfunction

    // Merge store data into the old word: byte lane k, halfword lane h, or the whole word.
    function automatic logic [word_size-1:0] store_merge(
        input logic [word_size-1:0] old, input logic [word_size-1:0] wdata,
        input logic [2:0] f3, input logic [1:0] off);
        logic [word_size-1:0] res;
        res = old;
        case (f3)
            3'b000:  res[{off, 3'b000} +: 8]     = wdata[7:0];
            3'b001:  res[{off[1], 4'b0000} +: 16] = wdata[15:0];
            3'b010:  res = wdata;
            default: res = old;
        endcase
        return res;
    endfunction

    state_t                   state_q, state_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [word_size-1:0]     wr_data_q, wr_data_d;
    logic [word_size-1:0]     rdata_q, rdata_d;
    logic                     error_q, error_d;

    logic [address_width-1:0] aligned_addr_s;
    logic [1:0]               offset_s;
    logic                     req_ready_s;

    assign aligned_addr_s = {bus.req_addr[address_width-1:2], 2'b00};
    assign offset_s       = bus.req_addr[1:0];
    assign req_ready_s    = (state_q == IDLE) && !reset;

    // Next-state and capture logic: latch the result of the accepted request.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_s) begin
                    addr_d = aligned_addr_s;
                    if (req_bad(bus.req_we, bus.req_funct3, offset_s)) begin
                        error_d = 1'b1;
                        rdata_d = {word_size{1'b0}};
                        state_d = RESP;
                    end else if (bus.req_we) begin
                        error_d   = 1'b0;
                        rdata_d   = {word_size{1'b0}};
                        wr_data_d = store_merge(bus.mem_rd_data, bus.req_wdata,
                                                bus.req_funct3, offset_s);
                        state_d   = WRITE;
                    end else begin
                        error_d = 1'b0;
                        rdata_d = load_extract(bus.mem_rd_data, bus.req_funct3,
                                               offset_s);
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and captured-data registers. The reset is asynchronous, so
    // mem_we and rsp_valid fall as soon as reset asserts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= {address_width{1'b0}};
            wr_data_q <= {word_size{1'b0}};
            rdata_q   <= {word_size{1'b0}};
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
        end
    end

    // Outputs. In IDLE the memory address follows the request, so read data
    // is available in the accept cycle.
    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_error   = error_q;
    assign bus.mem_we      = (state_q == WRITE);
    assign bus.mem_addr    = (state_q == WRITE) ? addr_q : aligned_addr_s;
    assign bus.mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. It includes a small word memory model
// and hand-computed expected values.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.address_width(32), .word_size(32)) bus ();

    mem_access_unit #(.address_width(32), .word_size(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:63];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    // Memory model: bench preload port, or a synchronous write from the DUT.
    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;
    end

    assign bus.mem_rd_data = mem[bus.mem_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Issue a single request, then watch for the write pulse and the response.
    // exp_lat is 1 for loads and errors, and 2 for stores.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_lat, input logic [31:0] exp_wr);
        int          lat;
        int          we_cnt;
        logic [31:0] seen_addr, seen_wr, got_rdata;
        logic        got_err;
        lat = 0; we_cnt = 0; seen_addr = 32'd0; seen_wr = 32'd0;
        got_rdata = 32'd0; got_err = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wdata;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_cnt++; seen_addr = bus.mem_addr; seen_wr = bus.mem_wr_data;
            end
            if (bus.rsp_valid) begin
                lat = k; got_rdata = bus.rsp_rdata; got_err = bus.rsp_error;
            end
        end
        chk({tag, ".lat"},   32'(lat), 32'(exp_lat));
        chk({tag, ".rdata"}, got_rdata, exp_rdata);
        chk({tag, ".err"},   32'(got_err), 32'(exp_err));
        chk({tag, ".we_cnt"}, 32'(we_cnt), (exp_lat == 2) ? 32'd1 : 32'd0);
        if (exp_lat == 2) begin
            chk({tag, ".waddr"}, seen_addr, {addr[31:2], 2'b00});
            chk({tag, ".wdata"}, seen_wr, exp_wr);
        end
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".idle_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rv_cnt;
        reset = 1'b1; pre_en = 1'b0; pre_idx = 6'd0; pre_data = 32'd0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h13; bus.req_wdata = 32'd0;
        for (int i = 0; i < 8; i++) preload(6'(i), 32'd0);
        preload(6'd4, 32'h8899AABB);
        preload(6'd5, 32'h01020304);

        // Reset state
        @(negedge clk);
        chk("rst.ready", 32'(bus.req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rdata", bus.rsp_rdata, 32'd0);
        chk("rst.err", 32'(bus.rsp_error), 32'd0);
        chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst.wr_data", bus.mem_wr_data, 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'h10);
        reset = 1'b0;

        // Loads
        run_req("lw10",  1'b0, 3'b010, 32'h10, 32'd0, 32'h8899AABB, 1'b0, 1, 32'd0);
        run_req("lb13",  1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF88, 1'b0, 1, 32'd0);
        run_req("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, 32'h00000088, 1'b0, 1, 32'd0);
        run_req("lh12",  1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF8899, 1'b0, 1, 32'd0);
        run_req("lhu10", 1'b0, 3'b101, 32'h10, 32'd0, 32'h0000AABB, 1'b0, 1, 32'd0);
        run_req("lb10",  1'b0, 3'b000, 32'h10, 32'd0, 32'hFFFFFFBB, 1'b0, 1, 32'd0);

        // Stores
        run_req("sb11", 1'b1, 3'b000, 32'h11, 32'h12345677, 32'd0, 1'b0, 2, 32'h889977BB);
        chk("sb11.mem", mem[4], 32'h889977BB);
        run_req("lw_after_sb", 1'b0, 3'b010, 32'h10, 32'd0, 32'h889977BB, 1'b0, 1, 32'd0);
        run_req("sh12", 1'b1, 3'b001, 32'h12, 32'hDEADBEEF, 32'd0, 1'b0, 2, 32'hBEEF77BB);
        chk("sh12.mem", mem[4], 32'hBEEF77BB);

        // Errors
        run_req("e_lw12", 1'b0, 3'b010, 32'h12, 32'd0, 32'd0, 1'b1, 1, 32'd0);
        chk("e_lw12.mem", mem[4], 32'hBEEF77BB);
        run_req("e_sh11", 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'd0, 1'b1, 1, 32'd0);
        chk("e_sh11.mem", mem[4], 32'hBEEF77BB);
        run_req("e_s100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'd0, 1'b1, 1, 32'd0);
        chk("e_s100.mem", mem[4], 32'hBEEF77BB);
        run_req("e_l011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1, 32'd0);
        chk("e_l011.mem", mem[4], 32'hBEEF77BB);

        // Back-to-back SB then LW, with req_valid held high
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h00000055;
        @(posedge clk);
        #1 bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        @(negedge clk);
        chk("b2b.write_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b.write_we", 32'(bus.mem_we), 32'd1);
        @(negedge clk);
        chk("b2b.resp_ready", 32'(bus.req_ready), 32'd0);
        chk("b2b.resp_valid", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        chk("b2b.idle_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b.lw_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b.lw_rdata", bus.rsp_rdata, 32'hBEEF7755);

        // Back-to-back LW, LW: accepts two cycles apart
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10;
        @(posedge clk);
        #1 bus.req_addr = 32'h14;
        @(negedge clk);
        chk("lwlw.first_valid", 32'(bus.rsp_valid), 32'd1);
        chk("lwlw.first_rdata", bus.rsp_rdata, 32'hBEEF7755);
        chk("lwlw.resp_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("lwlw.gap_valid", 32'(bus.rsp_valid), 32'd0);
        chk("lwlw.gap_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("lwlw.second_valid", 32'(bus.rsp_valid), 32'd1);
        chk("lwlw.second_rdata", bus.rsp_rdata, 32'h01020304);

        // Reset during WRITE of SW 0x10 <- 0
        preload(6'd4, 32'h8899AABB);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h00000000;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstw.we_before", 32'(bus.mem_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("rstw.we_drop", 32'(bus.mem_we), 32'd0);
        chk("rstw.ready_in_rst", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstw.ready_after", 32'(bus.req_ready), 32'd1);
        rv_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) rv_cnt++;
        end
        chk("rstw.no_rsp", 32'(rv_cnt), 32'd0);
        chk("rstw.mem", mem[4], 32'h8899AABB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
